// File: rtl/fsm_trace_buf.sv
// Change-detecting trace buffer: each distinct {x,y,z} sample from an upstream FSM is queued
// with a 4-bit sequence tag, so a dropped entry shows up as a gap in out_seq.
module fsm_trace_buf #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            x,
    input  logic [W-1:0]            y,
    input  logic [W-1:0]            z,
    input  logic                    in_en,
    input  logic                    clear,
    input  logic                    rd_ready,
    output logic                    out_valid,
    output logic [W-1:0]            out_x,
    output logic [W-1:0]            out_y,
    output logic [W-1:0]            out_z,
    output logic [3:0]              out_seq,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [2:0]              drops
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    logic [0:0]   state_q,    state_d;
    logic [W-1:0] lastX_q,    lastX_d;
    logic [W-1:0] lastY_q,    lastY_d;
    logic [W-1:0] lastZ_q,    lastZ_d;
    logic [3:0]   seqCtr_q,   seqCtr_d;
    logic [AW-1:0] wrPtr_q,   wrPtr_d;
    logic [AW-1:0] rdPtr_q,   rdPtr_d;
    logic [AW:0]  count_q,    count_d;
    logic         overflow_q, overflow_d;
    logic [2:0]   drops_q,    drops_d;

    logic [W-1:0] memX_q   [DEPTH];
    logic [W-1:0] memY_q   [DEPTH];
    logic [W-1:0] memZ_q   [DEPTH];
    logic [3:0]   memSeq_q [DEPTH];

    logic changeEvt;
    logic popEvt;
    logic pushEvt;
    logic dropEvt;
    logic fifoFull;

    // A clear in the same cycle swallows any change event or pop.
    assign fifoFull  = (count_q == FULL_COUNT);
    assign changeEvt = in_en && !clear &&
                       ((state_q == IDLE) || ({x, y, z} != {lastX_q, lastY_q, lastZ_q}));
    assign popEvt    = (count_q != '0) && rd_ready && !clear;
    assign pushEvt   = changeEvt && (!fifoFull || popEvt);
    assign dropEvt   = changeEvt && fifoFull && !popEvt;

    always_comb begin
        state_d    = state_q;
        lastX_d    = lastX_q;
        lastY_d    = lastY_q;
        lastZ_d    = lastZ_q;
        seqCtr_d   = seqCtr_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drops_d    = drops_q;

        if (clear) begin
            state_d    = IDLE;
            seqCtr_d   = 4'd0;
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drops_d    = 3'd0;
        end else begin
            // The tag advances even for dropped events so the consumer can see the loss.
            if (changeEvt) begin
                state_d  = TRACK;
                lastX_d  = x;
                lastY_d  = y;
                lastZ_d  = z;
                seqCtr_d = seqCtr_q + 4'd1;
            end
            if (pushEvt) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (popEvt) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({pushEvt, popEvt})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (dropEvt) begin
                overflow_d = 1'b1;
                if (drops_q != 3'd7) begin
                    drops_d = drops_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lastX_q    <= '0;
            lastY_q    <= '0;
            lastZ_q    <= '0;
            seqCtr_q   <= 4'd0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drops_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            lastX_q    <= lastX_d;
            lastY_q    <= lastY_d;
            lastZ_q    <= lastZ_d;
            seqCtr_q   <= seqCtr_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    // Storage is reset as well so the head outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                memX_q[i]   <= '0;
                memY_q[i]   <= '0;
                memZ_q[i]   <= '0;
                memSeq_q[i] <= 4'd0;
            end
        end else if (pushEvt) begin
            memX_q[wrPtr_q]   <= x;
            memY_q[wrPtr_q]   <= y;
            memZ_q[wrPtr_q]   <= z;
            memSeq_q[wrPtr_q] <= seqCtr_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_x     = memX_q[rdPtr_q];
    assign out_y     = memY_q[rdPtr_q];
    assign out_z     = memZ_q[rdPtr_q];
    assign out_seq   = memSeq_q[rdPtr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drops     = drops_q;

endmodule

// File: tb/tb_fsm_trace_buf.sv
// Directed bench for fsm_trace_buf: hand-computed expectations for fill, overflow, wrap,
// clear priority and asynchronous reset.
module tb_fsm_trace_buf;

    logic       clk;
    logic       rst;
    logic [4:0] x, y, z;
    logic       in_en;
    logic       clear;
    logic       rd_ready;
    logic       out_valid;
    logic [4:0] out_x, out_y, out_z;
    logic [3:0] out_seq;
    logic [2:0] count;
    logic       overflow;
    logic [2:0] drops;

    int testsRun    = 0;
    int testsFailed = 0;

    fsm_trace_buf #(.W(5), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .z        (z),
        .in_en    (in_en),
        .clear    (clear),
        .rd_ready (rd_ready),
        .out_valid(out_valid),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_z    (out_z),
        .out_seq  (out_seq),
        .count    (count),
        .overflow (overflow),
        .drops    (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit after the next.
    task automatic applyStimulus(input logic en, input logic [4:0] xv, input logic [4:0] yv,
                                 input logic [4:0] zv, input logic rdy, input logic clr);
        in_en    = en;
        x        = xv;
        y        = yv;
        z        = zv;
        rd_ready = rdy;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int expSeq [3];
        expSeq = '{2, 3, 6};

        rst = 1'b0; in_en = 1'b0; clear = 1'b0; rd_ready = 1'b0;
        x = '0; y = '0; z = '0;
        #12;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset count",     count,     0);
        checkOutput("reset overflow",  overflow,  0);
        checkOutput("reset drops",     drops,     0);
        checkOutput("reset out_x",     out_x,     0);
        checkOutput("reset out_seq",   out_seq,   0);
        #1 rst = 1'b1;

        // Repeated identical triple is recorded only once.
        applyStimulus(1, 1, 2, 3, 0, 0);
        checkOutput("first valid", out_valid, 1);
        checkOutput("first count", count,     1);
        checkOutput("first x",     out_x,     1);
        checkOutput("first y",     out_y,     2);
        checkOutput("first z",     out_z,     3);
        checkOutput("first seq",   out_seq,   0);
        applyStimulus(1, 1, 2, 3, 0, 0);
        applyStimulus(1, 1, 2, 3, 0, 0);
        checkOutput("repeat count", count, 1);
        applyStimulus(0, 9, 9, 9, 0, 0);
        checkOutput("in_en low count", count, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("clear count", count,     0);
        checkOutput("clear valid", out_valid, 0);

        // Six distinct triples into a four-deep buffer.
        for (int k = 1; k <= 6; k++) applyStimulus(1, 5'(k), 5'(k), 5'(k), 0, 0);
        checkOutput("full count",    count,    4);
        checkOutput("full overflow", overflow, 1);
        checkOutput("full drops",    drops,    2);
        checkOutput("full head seq", out_seq,  0);
        checkOutput("full head x",   out_x,    1);

        // Push while full is accepted when the head is popped the same cycle.
        applyStimulus(1, 7, 7, 7, 1, 0);
        checkOutput("pushpop count",    count,    4);
        checkOutput("pushpop overflow", overflow, 1);
        checkOutput("pushpop drops",    drops,    2);
        checkOutput("pushpop head seq", out_seq,  1);
        checkOutput("pushpop head x",   out_x,    2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            checkOutput("drain seq", out_seq, 32'(expSeq[i]));
        end
        checkOutput("drain last x", out_x, 7);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("drained count", count,     0);
        checkOutput("drained valid", out_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("empty pop count", count, 0);

        // Streaming with the consumer always ready: tag wraps 15 -> 0.
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1, 5'(k + 1), 5'(k), 0, 1, 0);
            checkOutput("stream seq",   out_seq, 32'(k % 16));
            checkOutput("stream count", count,   1);
        end
        checkOutput("stream drops",    drops,    0);
        checkOutput("stream overflow", overflow, 0);

        // Saturating drop counter, then clear beating a simultaneous event and pop.
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 13; k++) applyStimulus(1, 5'(k), 0, 0, 0, 0);
        checkOutput("sat drops",    drops,    7);
        checkOutput("sat overflow", overflow, 1);
        checkOutput("sat count",    count,    4);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("pre-clear count", count, 3);
        applyStimulus(1, 20, 20, 20, 1, 1);
        checkOutput("clr count",    count,     0);
        checkOutput("clr overflow", overflow,  0);
        checkOutput("clr drops",    drops,     0);
        checkOutput("clr valid",    out_valid, 0);
        applyStimulus(1, 13, 0, 0, 0, 0);
        checkOutput("post-clear count", count,   1);
        checkOutput("post-clear seq",   out_seq, 0);
        checkOutput("post-clear x",     out_x,   13);

        // Asynchronous reset between edges with two entries held.
        applyStimulus(1, 14, 0, 0, 0, 0);
        checkOutput("pre-reset count", count, 2);
        #2 rst = 1'b0;
        #1;
        checkOutput("async valid", out_valid, 0);
        checkOutput("async count", count,     0);
        checkOutput("async x",     out_x,     0);
        #2 rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("after reset count", count,     0);
        checkOutput("after reset valid", out_valid, 0);
        applyStimulus(1, 14, 0, 0, 0, 0);
        checkOutput("first after reset count", count,   1);
        checkOutput("first after reset seq",   out_seq, 0);
        checkOutput("first after reset x",     out_x,   14);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
